// File: rtl/jellyvl_synctimer_timer_core_pkg.sv
// Shared synctimer definitions: time type, adjust sign encoding and the
// signed adjust accumulator type with its wrap-around update helper.
package jellyvl_synctimer_timer_core_pkg;

  localparam int TIMER_WIDTH_DEF = 64;

  typedef logic [TIMER_WIDTH_DEF-1:0] timer_t;

  localparam logic SIGN_ADVANCE = 1'b0;
  localparam logic SIGN_RETARD  = 1'b1;

  typedef logic signed [15:0] accum_t;

  // Net adjust counter step; wraps silently at the 16-bit boundary.
  function automatic accum_t accum_step(input accum_t acc, input logic sign);
    if (sign == SIGN_RETARD) begin
      return acc - 16'sd1;
    end
    return acc + 16'sd1;
  endfunction

endpackage

// File: rtl/jellyvl_synctimer_frac_step.sv
// Fractional step accumulator: emits a carry whenever the running
// numerator sum reaches the denominator, giving STEP_NUM/STEP_DEN per clock.
module jellyvl_synctimer_frac_step #(
  parameter int STEP_NUM   = 0,
  parameter int STEP_DEN   = 1,
  parameter int FRAC_WIDTH = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic carry
);

  localparam logic [FRAC_WIDTH:0] NUM_X = (FRAC_WIDTH+1)'(STEP_NUM);
  localparam logic [FRAC_WIDTH:0] DEN_X = (FRAC_WIDTH+1)'(STEP_DEN);

  logic [FRAC_WIDTH-1:0] r_frac;
  logic [FRAC_WIDTH:0]   w_sum;
  logic [FRAC_WIDTH:0]   w_wrapped;
  logic                  w_carry;

  // The extra sum bit keeps frac + STEP_NUM exact before the compare.
  always_comb begin
    w_sum     = {1'b0, r_frac} + NUM_X;
    w_carry   = (w_sum >= DEN_X);
    w_wrapped = w_sum - DEN_X;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_frac <= '0;
    end else if (w_carry) begin
      r_frac <= w_wrapped[FRAC_WIDTH-1:0];
    end else begin
      r_frac <= w_sum[FRAC_WIDTH-1:0];
    end
  end

  assign carry = w_carry;

endmodule

// File: rtl/jellyvl_synctimer_timer_core.sv
// Synctimer local time counter: nominal (fractional) step per clock plus
// one-LSB corrections from the adjust handshake, with absolute time load.
module jellyvl_synctimer_timer_core
  import jellyvl_synctimer_timer_core_pkg::*;
#(
  parameter int                     TIMER_WIDTH     = 64,
  parameter int                     STEP_INT        = 1,
  parameter int                     STEP_NUM        = 0,
  parameter int                     STEP_DEN        = 1,
  parameter int                     FRAC_WIDTH      = 32,
  parameter int                     ADJUST_INTERVAL = 0,
  parameter logic [TIMER_WIDTH-1:0] INIT_TIME       = '0
) (
  input  logic                   reset,
  input  logic                   clk,
  input  logic [TIMER_WIDTH-1:0] set_time,
  input  logic                   set_valid,
  input  logic                   adjust_sign,
  input  logic                   adjust_valid,
  output logic                   adjust_ready,
  output logic [TIMER_WIDTH-1:0] current_time,
  output logic                   time_valid,
  output accum_t                 adjust_accum
);

  localparam int                HOLD_W    = $clog2(ADJUST_INTERVAL + 2);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(ADJUST_INTERVAL);

  logic [TIMER_WIDTH-1:0] r_time;
  logic [HOLD_W-1:0]      r_hold;
  logic                   r_ready;
  logic                   r_valid;
  accum_t                 r_accum;

  logic                   w_carry;
  logic                   w_xfer;
  logic                   w_adv;
  logic                   w_ret;
  logic [HOLD_W-1:0]      w_hold_next;
  logic [TIMER_WIDTH-1:0] w_time_next;

  jellyvl_synctimer_frac_step #(
    .STEP_NUM   (STEP_NUM),
    .STEP_DEN   (STEP_DEN),
    .FRAC_WIDTH (FRAC_WIDTH)
  ) u_frac_step (
    .clk   (clk),
    .reset (reset),
    .clear (set_valid),
    .carry (w_carry)
  );

  // Ready is registered from the next holdoff value, so a transfer closes
  // the window in the very next cycle and reopens it INTERVAL cycles later.
  always_comb begin
    w_xfer = adjust_valid && r_ready;
    w_adv  = w_xfer && (adjust_sign == SIGN_ADVANCE);
    w_ret  = w_xfer && (adjust_sign == SIGN_RETARD);

    if (w_xfer) begin
      w_hold_next = HOLD_LOAD;
    end else if (r_hold != '0) begin
      w_hold_next = r_hold - 1'b1;
    end else begin
      w_hold_next = '0;
    end

    w_time_next = r_time
                + TIMER_WIDTH'(STEP_INT)
                + TIMER_WIDTH'(w_carry)
                + TIMER_WIDTH'(w_adv)
                - TIMER_WIDTH'(w_ret);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_time  <= INIT_TIME;
      r_hold  <= '0;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
      r_accum <= '0;
    end else begin
      r_hold  <= w_hold_next;
      r_ready <= (w_hold_next == '0);
      // A load swallows any adjust accepted in the same cycle.
      if (set_valid) begin
        r_time  <= set_time;
        r_accum <= '0;
        r_valid <= 1'b1;
      end else begin
        r_time <= w_time_next;
        if (w_xfer) begin
          r_accum <= accum_step(r_accum, adjust_sign);
        end
      end
    end
  end

  assign adjust_ready = r_ready;
  assign current_time = r_time;
  assign time_valid   = r_valid;
  assign adjust_accum = r_accum;

endmodule

// File: tb/tb_jellyvl_synctimer_timer_core.sv
// Directed bench: three timer instances cover integer stepping, fractional
// stepping and adjust holdoff, each with its own reset and inputs.
module tb_jellyvl_synctimer_timer_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // u0: STEP_INT=1, no fraction, ADJUST_INTERVAL=0
  logic               a_reset, a_set_valid, a_sign, a_valid, a_ready, a_tv;
  logic [63:0]        a_set_time, a_time;
  logic signed [15:0] a_acc;

  jellyvl_synctimer_timer_core #(
    .TIMER_WIDTH(64), .STEP_INT(1), .STEP_NUM(0), .STEP_DEN(1),
    .FRAC_WIDTH(32), .ADJUST_INTERVAL(0), .INIT_TIME(64'd0)
  ) u0 (
    .reset(a_reset), .clk(clk), .set_time(a_set_time), .set_valid(a_set_valid),
    .adjust_sign(a_sign), .adjust_valid(a_valid), .adjust_ready(a_ready),
    .current_time(a_time), .time_valid(a_tv), .adjust_accum(a_acc)
  );

  // u1: STEP_INT=8 with 1/3 fractional step
  logic               b_reset, b_ready, b_tv;
  logic [63:0]        b_time;
  logic signed [15:0] b_acc;

  jellyvl_synctimer_timer_core #(
    .TIMER_WIDTH(64), .STEP_INT(8), .STEP_NUM(1), .STEP_DEN(3),
    .FRAC_WIDTH(32), .ADJUST_INTERVAL(0), .INIT_TIME(64'd0)
  ) u1 (
    .reset(b_reset), .clk(clk), .set_time(64'd0), .set_valid(1'b0),
    .adjust_sign(1'b0), .adjust_valid(1'b0), .adjust_ready(b_ready),
    .current_time(b_time), .time_valid(b_tv), .adjust_accum(b_acc)
  );

  // u2: STEP_INT=1, ADJUST_INTERVAL=3
  logic               c_reset, c_set_valid, c_sign, c_valid, c_ready, c_tv;
  logic [63:0]        c_set_time, c_time;
  logic signed [15:0] c_acc;

  jellyvl_synctimer_timer_core #(
    .TIMER_WIDTH(64), .STEP_INT(1), .STEP_NUM(0), .STEP_DEN(1),
    .FRAC_WIDTH(32), .ADJUST_INTERVAL(3), .INIT_TIME(64'd0)
  ) u2 (
    .reset(c_reset), .clk(clk), .set_time(c_set_time), .set_valid(c_set_valid),
    .adjust_sign(c_sign), .adjust_valid(c_valid), .adjust_ready(c_ready),
    .current_time(c_time), .time_valid(c_tv), .adjust_accum(c_acc)
  );

  initial begin
    logic [63:0] prev;
    logic [63:0] exp_t;
    int          exp_acc;

    a_reset = 1'b1; a_set_valid = 1'b0; a_set_time = '0; a_sign = 1'b0; a_valid = 1'b0;
    b_reset = 1'b1;
    c_reset = 1'b1; c_set_valid = 1'b0; c_set_time = '0; c_sign = 1'b0; c_valid = 1'b0;
    tick();
    tick();

    chk("u0 reset time",  a_time, 64'd0);
    chk("u0 reset ready", 64'(a_ready), 64'd0);
    chk("u0 reset tv",    64'(a_tv), 64'd0);
    chk("u0 reset acc",   64'(a_acc), 64'd0);

    // Plain counting from release
    a_reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("u0 count %0d", k), a_time, 64'(k));
      chk($sformatf("u0 ready %0d", k), 64'(a_ready), 64'd1);
    end

    // Single retard: increment drops to 0 for one cycle
    a_valid = 1'b1; a_sign = 1'b1;
    tick();
    chk("u0 retard hold", a_time, 64'd4);
    chk("u0 retard acc",  64'(a_acc), -64'sd1);
    a_valid = 1'b0; a_sign = 1'b0;
    tick();
    chk("u0 retard resume", a_time, 64'd5);

    // Set coinciding with an advance transfer
    a_set_valid = 1'b1; a_set_time = 64'h1000; a_valid = 1'b1; a_sign = 1'b0;
    tick();
    chk("u0 set time", a_time, 64'h1000);
    chk("u0 set acc",  64'(a_acc), 64'd0);
    chk("u0 set tv",   64'(a_tv), 64'd1);
    a_set_valid = 1'b0; a_valid = 1'b0;
    tick();
    chk("u0 after set", a_time, 64'h1001);

    // Wrap: 2^64-2 + 1 + 1 = 0
    a_set_valid = 1'b1; a_set_time = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    chk("u0 near wrap", a_time, 64'hFFFF_FFFF_FFFF_FFFE);
    a_set_valid = 1'b0; a_valid = 1'b1; a_sign = 1'b0;
    tick();
    chk("u0 wrap zero", a_time, 64'd0);
    chk("u0 wrap acc",  64'(a_acc), 64'd1);
    a_valid = 1'b0;
    tick();
    chk("u0 wrap +1", a_time, 64'd1);
    tick();
    chk("u0 wrap +2", a_time, 64'd2);

    // Fractional stepping 8,8,9 and 300-cycle total
    b_reset = 1'b0;
    prev = 64'd0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i <= 6) begin
        chk($sformatf("u1 delta %0d", i), b_time - prev, (i % 3 == 0) ? 64'd9 : 64'd8);
      end
      prev = b_time;
    end
    chk("u1 t300", b_time, 64'd2500);

    // Holdoff with adjust_valid held high
    c_reset = 1'b0;
    tick();
    chk("u2 first ready", 64'(c_ready), 64'd1);
    chk("u2 first time",  c_time, 64'd1);
    chk("u2 tv before set", 64'(c_tv), 64'd0);
    exp_t = 64'd1;
    exp_acc = 0;
    c_valid = 1'b1; c_sign = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (n % 4 == 1) begin
        exp_t   = exp_t + 64'd2;
        exp_acc = exp_acc + 1;
      end else begin
        exp_t = exp_t + 64'd1;
      end
      chk($sformatf("u2 ready %0d", n), 64'(c_ready), (n % 4 == 0) ? 64'd1 : 64'd0);
      chk($sformatf("u2 time %0d", n),  c_time, exp_t);
      chk($sformatf("u2 acc %0d", n),   64'(c_acc), 64'(exp_acc));
    end

    // Transfer opens a holdoff, then reset cancels it
    tick();
    chk("u2 in holdoff", 64'(c_ready), 64'd0);
    c_reset = 1'b1; c_valid = 1'b0;
    tick();
    chk("u2 rst ready", 64'(c_ready), 64'd0);
    chk("u2 rst time",  c_time, 64'd0);
    chk("u2 rst acc",   64'(c_acc), 64'd0);
    c_reset = 1'b0;
    tick();
    chk("u2 rel ready", 64'(c_ready), 64'd1);
    chk("u2 rel time",  c_time, 64'd1);

    // Set + transfer: adjust discarded but holdoff still loaded
    c_set_valid = 1'b1; c_set_time = 64'h1000; c_valid = 1'b1; c_sign = 1'b0;
    tick();
    chk("u2 set time",  c_time, 64'h1000);
    chk("u2 set acc",   64'(c_acc), 64'd0);
    chk("u2 set tv",    64'(c_tv), 64'd1);
    chk("u2 set ready", 64'(c_ready), 64'd0);
    c_set_valid = 1'b0; c_valid = 1'b0;
    for (int m = 1; m <= 3; m++) begin
      tick();
      chk($sformatf("u2 post-set time %0d", m), c_time, 64'h1000 + 64'(m));
      chk($sformatf("u2 post-set ready %0d", m), 64'(c_ready), (m == 3) ? 64'd1 : 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
